// File: rtl/aram_arbiter.sv
// aram_arbiter: shares one single-port audio RAM between the SPC700 CPU (port C)
// and the DSP sample/echo engine (port D). One access is issued per cycle, the
// DSP normally wins, and a burst limiter guarantees the CPU a slot after
// DSP_BURST_MAX consecutive contended DSP grants. Read data is tagged to its
// owner through a short pipe matching the RAM read latency.
module aram_arbiter #(
  parameter int DSP_BURST_MAX = 3,
  parameter int READ_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_c_req,
  input  logic [15:0] in_c_address,
  input  logic [7:0]  in_c_write,
  input  logic        in_c_we,
  output logic        out_c_grant,
  output logic        out_c_rvalid,
  input  logic        in_d_req,
  input  logic [15:0] in_d_address,
  input  logic [7:0]  in_d_write,
  input  logic        in_d_we,
  output logic        out_d_grant,
  output logic        out_d_rvalid,
  output logic [7:0]  out_rdata,
  output logic [15:0] out_ram_address,
  output logic [7:0]  out_ram_write,
  output logic        out_ram_write_enable,
  input  logic [7:0]  in_ram_read,
  output logic [15:0] out_c_stall_count
);

  // Consecutive DSP grants taken while the CPU was waiting.
  logic [3:0] burst_cnt;
  logic       burst_full;

  // One {valid, owner} tag per outstanding read; owner 1 means DSP.
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_owner;
  logic                    read_issue;

  assign burst_full = (burst_cnt == 4'(DSP_BURST_MAX));

  // Arbitration and RAM drive, purely combinational from the requests so a
  // grant lands in the same cycle as the request.
  always_comb begin
    out_c_grant          = 1'b0;
    out_d_grant          = 1'b0;
    out_ram_address      = 16'h0000;
    out_ram_write        = 8'h00;
    out_ram_write_enable = 1'b0;
    read_issue           = 1'b0;
    if (!reset) begin
      if (in_c_req && (!in_d_req || burst_full)) begin
        out_c_grant = 1'b1;
      end else if (in_d_req) begin
        out_d_grant = 1'b1;
      end
      if (out_c_grant) begin
        out_ram_address      = in_c_address;
        out_ram_write        = in_c_write;
        out_ram_write_enable = in_c_we;
        read_issue           = !in_c_we;
      end else if (out_d_grant) begin
        out_ram_address      = in_d_address;
        out_ram_write        = in_d_write;
        out_ram_write_enable = in_d_we;
        read_issue           = !in_d_we;
      end
    end
  end

  // Burst limiter: counts DSP wins against a waiting CPU and restarts
  // whenever the CPU gets through or stops asking.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (out_c_grant || !in_c_req) begin
      burst_cnt <= 4'd0;
    end else if (out_d_grant) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Tag pipe that follows each granted read until its data comes back;
  // reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= read_issue;
      tag_owner[0] <= out_d_grant;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  // Saturating count of cycles where the CPU asked but was not served.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_c_stall_count <= 16'h0000;
    end else if (in_c_req && !out_c_grant && (out_c_stall_count != 16'hFFFF)) begin
      out_c_stall_count <= out_c_stall_count + 16'd1;
    end
  end

  assign out_c_rvalid = !reset && tag_valid[READ_LATENCY-1] && !tag_owner[READ_LATENCY-1];
  assign out_d_rvalid = !reset && tag_valid[READ_LATENCY-1] &&  tag_owner[READ_LATENCY-1];
  assign out_rdata    = in_ram_read;

endmodule

// File: tb/tb_aram_arbiter.sv
// tb_aram_arbiter: drives two arbiters (default parameters, and
// DSP_BURST_MAX=15 / READ_LATENCY=3) from the same requests, each with its own
// RAM, and compares every cycle against a behavioural model of the sharing rules.
module tb_aram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] c_addr = 16'h0000, d_addr = 16'h0000;
  logic [7:0]  c_wdata = 8'h00, d_wdata = 8'h00;

  logic        c_grant [2];
  logic        d_grant [2];
  logic        c_rvalid [2];
  logic        d_rvalid [2];
  logic [7:0]  rdata [2];
  logic [15:0] ram_addr [2];
  logic [7:0]  ram_wdata [2];
  logic        ram_we [2];
  logic [15:0] stall [2];

  logic [7:0]  ram_mem [2][65536];
  logic [7:0]  rpipe [2][4];

  typedef struct packed {
    logic       valid;
    logic       owner;
    logic [7:0] data;
  } issue_t;

  logic [7:0]  mdl_mem [2][65536];
  issue_t      hist [2][8];
  int          mdl_burst [2];
  int          mdl_stall [2];
  int          max_burst [2] = '{3, 15};
  int          lat [2] = '{1, 3};
  logic        mg_c = 1'b0, mg_d = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;

  aram_arbiter #(.DSP_BURST_MAX(3), .READ_LATENCY(1)) dut0 (
    .clock(clock), .reset(reset),
    .in_c_req(c_req), .in_c_address(c_addr), .in_c_write(c_wdata), .in_c_we(c_we),
    .out_c_grant(c_grant[0]), .out_c_rvalid(c_rvalid[0]),
    .in_d_req(d_req), .in_d_address(d_addr), .in_d_write(d_wdata), .in_d_we(d_we),
    .out_d_grant(d_grant[0]), .out_d_rvalid(d_rvalid[0]),
    .out_rdata(rdata[0]), .out_ram_address(ram_addr[0]), .out_ram_write(ram_wdata[0]),
    .out_ram_write_enable(ram_we[0]), .in_ram_read(rpipe[0][0]),
    .out_c_stall_count(stall[0])
  );

  aram_arbiter #(.DSP_BURST_MAX(15), .READ_LATENCY(3)) dut1 (
    .clock(clock), .reset(reset),
    .in_c_req(c_req), .in_c_address(c_addr), .in_c_write(c_wdata), .in_c_we(c_we),
    .out_c_grant(c_grant[1]), .out_c_rvalid(c_rvalid[1]),
    .in_d_req(d_req), .in_d_address(d_addr), .in_d_write(d_wdata), .in_d_we(d_we),
    .out_d_grant(d_grant[1]), .out_d_rvalid(d_rvalid[1]),
    .out_rdata(rdata[1]), .out_ram_address(ram_addr[1]), .out_ram_write(ram_wdata[1]),
    .out_ram_write_enable(ram_we[1]), .in_ram_read(rpipe[1][2]),
    .out_c_stall_count(stall[1])
  );

  always #5 clock = ~clock;

  // Synchronous RAM per instance with a read pipe as deep as that instance's latency.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_we[k]) ram_mem[k][ram_addr[k]] <= ram_wdata[k];
      rpipe[k][0] <= ram_mem[k][ram_addr[k]];
      for (int i = 1; i < 4; i++) rpipe[k][i] <= rpipe[k][i-1];
    end
  end

  task automatic check_output(input int k, input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL u%0d %s: got %0h expected %0h (cycle %0d)", k, name, act, exp, cyc);
  endtask

  // Model of one cycle of instance k: who must win, what the RAM must see,
  // which read (issued latency cycles ago) must come back, then advance state.
  task automatic model_cycle(input int k);
    logic       eg_c, eg_d, ewe, erv_c, erv_d;
    logic [15:0] ea;
    logic [7:0]  ew;
    issue_t      h;
    eg_c = 1'b0; eg_d = 1'b0; ea = 16'h0; ew = 8'h0; ewe = 1'b0;
    if (!reset) begin
      if (c_req && d_req) begin
        eg_c = (mdl_burst[k] == max_burst[k]);
        eg_d = !eg_c;
      end else begin
        eg_c = c_req;
        eg_d = d_req;
      end
      if (eg_c) begin ea = c_addr; ew = c_wdata; ewe = c_we; end
      if (eg_d) begin ea = d_addr; ew = d_wdata; ewe = d_we; end
    end
    h = hist[k][(cyc + 8 - lat[k]) % 8];
    erv_c = !reset && h.valid && !h.owner;
    erv_d = !reset && h.valid && h.owner;
    check_output(k, "c_grant", 32'(c_grant[k]), 32'(eg_c));
    check_output(k, "d_grant", 32'(d_grant[k]), 32'(eg_d));
    check_output(k, "ram_address", 32'(ram_addr[k]), 32'(ea));
    check_output(k, "ram_write", 32'(ram_wdata[k]), 32'(ew));
    check_output(k, "ram_we", 32'(ram_we[k]), 32'(ewe));
    check_output(k, "c_rvalid", 32'(c_rvalid[k]), 32'(erv_c));
    check_output(k, "d_rvalid", 32'(d_rvalid[k]), 32'(erv_d));
    check_output(k, "stall_count", 32'(stall[k]), 32'(mdl_stall[k]));
    if (erv_c || erv_d) check_output(k, "rdata", 32'(rdata[k]), 32'(h.data));
    if (reset) begin
      for (int i = 0; i < 8; i++) hist[k][i] = '0;
      mdl_burst[k] = 0;
      mdl_stall[k] = 0;
    end else begin
      hist[k][cyc % 8] = '{valid: (eg_c || eg_d) && !ewe, owner: eg_d, data: mdl_mem[k][ea]};
      if ((eg_c || eg_d) && ewe) mdl_mem[k][ea] = ew;
      if (eg_c || !c_req) mdl_burst[k] = 0;
      else if (eg_d) mdl_burst[k]++;
      if (c_req && !eg_c && mdl_stall[k] < 65535) mdl_stall[k]++;
    end
    if (k == 0) begin mg_c = eg_c; mg_d = eg_d; end
  endtask

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clock) begin
    model_cycle(0);
    model_cycle(1);
    cyc++;
  end

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'h0200 + 16'($urandom_range(0, 7));
  endfunction

  // New random requests once the previous one (as seen by instance 0) was
  // served; otherwise hold, with an occasional legal withdrawal.
  task automatic apply_stimulus();
    if (!c_req || mg_c) begin
      c_req = ($urandom_range(0, 9) < 6);
      c_addr = rand_addr(); c_wdata = 8'($urandom); c_we = ($urandom_range(0, 3) == 0);
    end else if ($urandom_range(0, 19) == 0) c_req = 1'b0;
    if (!d_req || mg_d) begin
      d_req = ($urandom_range(0, 9) < 6);
      d_addr = rand_addr(); d_wdata = 8'($urandom); d_we = ($urandom_range(0, 3) == 0);
    end else if ($urandom_range(0, 19) == 0) d_req = 1'b0;
    reset = ($urandom_range(0, 499) == 0);
  endtask

  task automatic next_drive();
    @(posedge clock); #1;
  endtask

  task automatic at_sample();
    @(negedge clock); #1;
  endtask

  logic [7:0] dpat;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 65536; a++) begin
        ram_mem[k][a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
        mdl_mem[k][a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      end
      ram_mem[k][16'h1234] = 8'hA5;
      mdl_mem[k][16'h1234] = 8'hA5;
      for (int i = 0; i < 4; i++) rpipe[k][i] = 8'h00;
      for (int i = 0; i < 8; i++) hist[k][i] = '0;
      mdl_burst[k] = 0;
      mdl_stall[k] = 0;
    end

    // Reset state
    repeat (2) @(posedge clock);
    at_sample();
    check_output(0, "reset grant", 32'({c_grant[0], d_grant[0], ram_we[0]}), 32'h0);
    check_output(0, "reset stall", 32'(stall[0]), 32'h0);
    next_drive();
    reset = 1'b0;

    // Lone CPU read of 0x1234
    c_req = 1'b1; c_addr = 16'h1234; c_we = 1'b0;
    at_sample();
    check_output(0, "t1 c_grant", 32'(c_grant[0]), 32'h1);
    check_output(0, "t1 address", 32'(ram_addr[0]), 32'h1234);
    next_drive();
    c_req = 1'b0;
    at_sample();
    check_output(0, "t1 c_rvalid", 32'(c_rvalid[0]), 32'h1);
    check_output(0, "t1 rdata", 32'(rdata[0]), 32'hA5);
    check_output(0, "t1 d_rvalid", 32'(d_rvalid[0]), 32'h0);

    // Continuous contention: D,D,D,C,D,D,D,C
    next_drive();
    c_req = 1'b1; c_addr = 16'h0300; d_req = 1'b1; d_addr = 16'h0301; d_we = 1'b0;
    dpat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      at_sample();
      check_output(0, "t2 d_grant", 32'(d_grant[0]), 32'(dpat[i]));
      next_drive();
    end
    c_req = 1'b0; d_req = 1'b0;
    at_sample();
    check_output(0, "t2 stall", 32'(stall[0]), 32'd6);

    // DSP write while CPU waits, then CPU reads the same byte back
    next_drive();
    d_req = 1'b1; d_addr = 16'h0200; d_wdata = 8'h55; d_we = 1'b1;
    c_req = 1'b1; c_addr = 16'h0200; c_we = 1'b0;
    at_sample();
    check_output(0, "t3 d_grant", 32'({d_grant[0], c_grant[0]}), 32'h2);
    check_output(0, "t3 we", 32'({ram_we[0], ram_wdata[0], ram_addr[0]}), 32'h1550200);
    next_drive();
    d_req = 1'b0; d_we = 1'b0;
    at_sample();
    check_output(0, "t3 c_grant", 32'({c_grant[0], ram_we[0]}), 32'h2);
    next_drive();
    c_req = 1'b0;
    at_sample();
    check_output(0, "t3 c_rvalid", 32'({c_rvalid[0], d_rvalid[0]}), 32'h2);
    check_output(0, "t3 rdata", 32'(rdata[0]), 32'h55);
    check_output(0, "t3 stall", 32'(stall[0]), 32'd7);

    // Reset right after a DSP read grant drops the read
    next_drive();
    d_req = 1'b1; d_addr = 16'h0010;
    at_sample();
    check_output(0, "t4 d_grant", 32'(d_grant[0]), 32'h1);
    next_drive();
    d_req = 1'b0; reset = 1'b1;
    at_sample();
    check_output(0, "t4 rvalid", 32'({d_rvalid[0], c_rvalid[0]}), 32'h0);
    next_drive();
    reset = 1'b0;
    at_sample();
    check_output(0, "t4 outputs", 32'({c_grant[0], d_grant[0], ram_we[0], ram_addr[0]}), 32'h0);
    check_output(0, "t4 stall", 32'(stall[0]), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_drive();
      apply_stimulus();
    end

    // Long contention: saturation on the 15-burst instance
    next_drive();
    c_req = 1'b0; d_req = 1'b0; reset = 1'b1;
    next_drive();
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0401;
    repeat (70000) @(posedge clock);
    #1;
    c_req = 1'b0; d_req = 1'b0;
    at_sample();
    check_output(0, "t5 stall", 32'(stall[0]), 32'd52500);
    check_output(1, "t5 stall saturated", 32'(stall[1]), 32'hFFFF);

    next_drive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
